// File: rtl/adam_boot_seq.sv
// Boot sequencer: holds every memory and CPU channel in reset/pause after
// power-on, then releases MEM0 and CPU0 in order, waiting for each channel's
// pause acknowledge to drop (bounded by a timeout) before moving on.
module adam_boot_seq #(
  parameter int unsigned NO_CPUS           = 1,
  parameter int unsigned NO_MEMS           = 3,
  parameter int unsigned RST_CYCLES        = 5,
  parameter logic [31:0] RST_BOOT_ADDR     = 32'h0100_0000,
  parameter bit          EN_BOOTSTRAP_CPU0 = 1'b1,
  parameter bit          EN_BOOTSTRAP_MEM0 = 1'b1,
  parameter int unsigned ACK_TIMEOUT       = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [NO_MEMS-1:0] mem_rst,
  output logic [NO_MEMS-1:0] mem_pause_req,
  input  logic [NO_MEMS-1:0] mem_pause_ack,
  output logic [NO_CPUS-1:0] cpu_rst,
  output logic [NO_CPUS-1:0] cpu_pause_req,
  input  logic [NO_CPUS-1:0] cpu_pause_ack,
  output logic [31:0]        cpu0_boot_addr,
  output logic               boot_done,
  output logic               boot_err
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned WAIT_W = 16;

  // Terminal counts: the counters start at 0, so the last cycle is N-1.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    MEM_REL  = 3'd1,
    MEM_WAIT = 3'd2,
    CPU_REL  = 3'd3,
    CPU_WAIT = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Successor states are fixed by the bootstrap enables at elaboration time.
  localparam state_t AFTER_MEM  = EN_BOOTSTRAP_CPU0 ? CPU_REL : DONE;
  localparam state_t AFTER_HOLD = EN_BOOTSTRAP_MEM0 ? MEM_REL : AFTER_MEM;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  // Only bit 0 of each ack vector is consumed; the rest are kept for symmetry.
  logic unused_ack_bits;
  assign unused_ack_bits = ^{mem_pause_ack, cpu_pause_ack};

  // Boot address is a constant strap, valid even while in reset.
  assign cpu0_boot_addr = RST_BOOT_ADDR;

  // Sequencer state, counters and registered channel controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HOLD;
      hold_cnt      <= '0;
      wait_cnt      <= '0;
      mem_rst       <= '1;
      mem_pause_req <= '1;
      cpu_rst       <= '1;
      cpu_pause_req <= '1;
      boot_done     <= 1'b0;
      boot_err      <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= AFTER_HOLD;
            if (AFTER_HOLD == MEM_REL) mem_rst[0] <= 1'b0;
            if (AFTER_HOLD == CPU_REL) cpu_rst[0] <= 1'b0;
            if (AFTER_HOLD == DONE)    boot_done  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        MEM_REL: begin
          state            <= MEM_WAIT;
          mem_pause_req[0] <= 1'b0;
          wait_cnt         <= '0;
        end

        MEM_WAIT: begin
          if (!mem_pause_ack[0] || (wait_cnt == WAIT_LAST)) begin
            // Timeout flags the error but still lets the boot proceed.
            if (mem_pause_ack[0]) boot_err <= 1'b1;
            state    <= AFTER_MEM;
            wait_cnt <= '0;
            if (AFTER_MEM == CPU_REL) cpu_rst[0] <= 1'b0;
            if (AFTER_MEM == DONE)    boot_done  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        CPU_REL: begin
          state            <= CPU_WAIT;
          cpu_pause_req[0] <= 1'b0;
          wait_cnt         <= '0;
        end

        CPU_WAIT: begin
          if (!cpu_pause_ack[0] || (wait_cnt == WAIT_LAST)) begin
            if (cpu_pause_ack[0]) boot_err <= 1'b1;
            state     <= DONE;
            wait_cnt  <= '0;
            boot_done <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        DONE: begin
          state <= DONE;
        end

        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adam_boot_seq.sv
// Bench for adam_boot_seq: four differently parameterised instances share
// clock and reset; acks respond after random delays and every output is
// compared each cycle against an event-time model of the boot sequence.
module tb_adam_boot_seq;

  localparam int NEV   = 1 << 30;
  localparam int STUCK = 1 << 20;

  // Per-instance configuration, mirrored in the instantiations below.
  int          rc_c [4] = '{5, 3, 4, 7};
  int          to_c [4] = '{255, 4, 8, 255};
  bit          enm_c[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit          enc_c[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int          nm_c [4] = '{3, 2, 3, 3};
  int          nc_c [4] = '{1, 2, 1, 1};
  logic [31:0] adr_c[4] = '{32'h0100_0000, 32'h8000_1234, 32'h0100_0000, 32'h0100_0000};

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  // Ack drop delays (cycles after pause_req falls) for the current run.
  int dm[4];
  int dc[4];
  int mlow[4];
  int clow[4];
  logic mack[4];
  logic cack[4];
  logic [7:0] junk;

  logic [2:0] mr0, mp0, ma0;  logic [0:0] cr0, cp0, ca0;  logic [31:0] ad0;  logic dn0, er0;
  logic [1:0] mr1, mp1, ma1;  logic [1:0] cr1, cp1, ca1;  logic [31:0] ad1;  logic dn1, er1;
  logic [2:0] mr2, mp2, ma2;  logic [0:0] cr2, cp2, ca2;  logic [31:0] ad2;  logic dn2, er2;
  logic [2:0] mr3, mp3, ma3;  logic [0:0] cr3, cp3, ca3;  logic [31:0] ad3;  logic dn3, er3;

  assign ma0 = {junk[1:0], mack[0]};  assign ca0 = cack[0];
  assign ma1 = {junk[2],   mack[1]};  assign ca1 = {junk[3], cack[1]};
  assign ma2 = {junk[5:4], mack[2]};  assign ca2 = cack[2];
  assign ma3 = {junk[7:6], mack[3]};  assign ca3 = cack[3];

  logic [31:0] o_mrst[4], o_mpr[4], o_crst[4], o_cpr[4], o_addr[4];
  logic        o_done[4], o_err[4];

  assign o_mrst[0] = 32'(mr0); assign o_mpr[0] = 32'(mp0); assign o_crst[0] = 32'(cr0);
  assign o_cpr[0]  = 32'(cp0); assign o_addr[0] = ad0; assign o_done[0] = dn0; assign o_err[0] = er0;
  assign o_mrst[1] = 32'(mr1); assign o_mpr[1] = 32'(mp1); assign o_crst[1] = 32'(cr1);
  assign o_cpr[1]  = 32'(cp1); assign o_addr[1] = ad1; assign o_done[1] = dn1; assign o_err[1] = er1;
  assign o_mrst[2] = 32'(mr2); assign o_mpr[2] = 32'(mp2); assign o_crst[2] = 32'(cr2);
  assign o_cpr[2]  = 32'(cp2); assign o_addr[2] = ad2; assign o_done[2] = dn2; assign o_err[2] = er2;
  assign o_mrst[3] = 32'(mr3); assign o_mpr[3] = 32'(mp3); assign o_crst[3] = 32'(cr3);
  assign o_cpr[3]  = 32'(cp3); assign o_addr[3] = ad3; assign o_done[3] = dn3; assign o_err[3] = er3;

  adam_boot_seq u0 (
    .clk(clk), .rst_n(rst_n),
    .mem_rst(mr0), .mem_pause_req(mp0), .mem_pause_ack(ma0),
    .cpu_rst(cr0), .cpu_pause_req(cp0), .cpu_pause_ack(ca0),
    .cpu0_boot_addr(ad0), .boot_done(dn0), .boot_err(er0)
  );

  adam_boot_seq #(
    .NO_CPUS(2), .NO_MEMS(2), .RST_CYCLES(3), .RST_BOOT_ADDR(32'h8000_1234), .ACK_TIMEOUT(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .mem_rst(mr1), .mem_pause_req(mp1), .mem_pause_ack(ma1),
    .cpu_rst(cr1), .cpu_pause_req(cp1), .cpu_pause_ack(ca1),
    .cpu0_boot_addr(ad1), .boot_done(dn1), .boot_err(er1)
  );

  adam_boot_seq #(
    .RST_CYCLES(4), .EN_BOOTSTRAP_MEM0(1'b0), .ACK_TIMEOUT(8)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
    .mem_rst(mr2), .mem_pause_req(mp2), .mem_pause_ack(ma2),
    .cpu_rst(cr2), .cpu_pause_req(cp2), .cpu_pause_ack(ca2),
    .cpu0_boot_addr(ad2), .boot_done(dn2), .boot_err(er2)
  );

  adam_boot_seq #(
    .RST_CYCLES(7), .EN_BOOTSTRAP_MEM0(1'b0), .EN_BOOTSTRAP_CPU0(1'b0)
  ) u3 (
    .clk(clk), .rst_n(rst_n),
    .mem_rst(mr3), .mem_pause_req(mp3), .mem_pause_ack(ma3),
    .cpu_rst(cr3), .cpu_pause_req(cp3), .cpu_pause_ack(ca3),
    .cpu0_boot_addr(ad3), .boot_done(dn3), .boot_err(er3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycles spent in a WAIT state for a given ack delay and timeout.
  function automatic int wait_len(input int d, input int t);
    int l;
    l = (d < 1) ? 1 : d;
    return (l < t) ? l : t;
  endfunction

  // Edge numbers (counted from reset release) at which each event happens.
  function automatic void event_times(input int i, output int t_mrel, output int x_m,
                                      output int t_crel, output int x_c, output int t_done);
    t_mrel = enm_c[i] ? rc_c[i] : NEV;
    x_m    = t_mrel + 1 + wait_len(dm[i], to_c[i]);
    t_crel = !enc_c[i] ? NEV : (enm_c[i] ? x_m : rc_c[i]);
    x_c    = t_crel + 1 + wait_len(dc[i], to_c[i]);
    t_done = enc_c[i] ? x_c : (enm_c[i] ? x_m : rc_c[i]);
  endfunction

  // Expected outputs after the k-th edge since release (k=0: reset values).
  task automatic check_inst(input int i, input int k);
    int t_mrel, x_m, t_crel, x_c, t_done;
    logic [31:0] e_mrst, e_mpr, e_crst, e_cpr;
    logic e_err;
    event_times(i, t_mrel, x_m, t_crel, x_c, t_done);
    e_mrst = 32'((1 << nm_c[i]) - 1);
    e_mpr  = e_mrst;
    e_crst = 32'((1 << nc_c[i]) - 1);
    e_cpr  = e_crst;
    if (k >= t_mrel)     e_mrst[0] = 1'b0;
    if (k >= t_mrel + 1) e_mpr[0]  = 1'b0;
    if (k >= t_crel)     e_crst[0] = 1'b0;
    if (k >= t_crel + 1) e_cpr[0]  = 1'b0;
    e_err = (enm_c[i] && (dm[i] > to_c[i]) && (k >= x_m)) ||
            (enc_c[i] && (dc[i] > to_c[i]) && (k >= x_c));
    check($sformatf("u%0d.mem_rst k=%0d", i, k),       o_mrst[i], e_mrst);
    check($sformatf("u%0d.mem_pause_req k=%0d", i, k), o_mpr[i],  e_mpr);
    check($sformatf("u%0d.cpu_rst k=%0d", i, k),       o_crst[i], e_crst);
    check($sformatf("u%0d.cpu_pause_req k=%0d", i, k), o_cpr[i],  e_cpr);
    check($sformatf("u%0d.boot_done k=%0d", i, k),     32'(o_done[i]), 32'(k >= t_done));
    check($sformatf("u%0d.boot_err k=%0d", i, k),      32'(o_err[i]), 32'(e_err));
    check($sformatf("u%0d.boot_addr k=%0d", i, k),     o_addr[i], adr_c[i]);
  endtask

  task automatic check_all(input int k);
    for (int i = 0; i < 4; i++) check_inst(i, k);
  endtask

  function automatic int pick_d();
    int r;
    r = int'($urandom_range(0, 9));
    return (r >= 8) ? STUCK : r;
  endfunction

  // One boot: reset hold, release, per-cycle checks, then async reset drop
  // either at abort_at (mid-cycle) or after everything has finished.
  task automatic run_seq(input int abort_at);
    int a, b, c, d, td, last;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      event_times(i, a, b, c, d, td);
      if (td > last) last = td;
      mlow[i] = 0;
      clow[i] = 0;
      mack[i] = (0 < dm[i]);
      cack[i] = (0 < dc[i]);
    end
    last = last + 3;
    if (abort_at > 0) last = abort_at;
    repeat (2) @(posedge clk);
    #1 check_all(0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1 check_all(k);
      for (int i = 0; i < 4; i++) begin
        if (o_mpr[i][0] == 1'b0) mlow[i]++;
        if (o_cpr[i][0] == 1'b0) clow[i]++;
        mack[i] = (mlow[i] < dm[i]);
        cack[i] = (clow[i] < dc[i]);
      end
      junk = 8'($urandom);
    end
    #2 rst_n = 1'b0;
    #1 check_all(0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    junk    = 8'h00;
    for (int i = 0; i < 4; i++) begin
      dm[i] = 2; dc[i] = 2; mack[i] = 1'b1; cack[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 check_all(0);

    // Acks drop two cycles after each request; u1 MEM0 ack never drops.
    dm[1] = STUCK;
    run_seq(0);

    // Acks already low when the channels are released.
    for (int i = 0; i < 4; i++) begin dm[i] = 0; dc[i] = 0; end
    run_seq(0);

    // Reset pulse while u0 sits in CPU_WAIT, then a clean full sequence.
    for (int i = 0; i < 4; i++) begin dm[i] = pick_d(); dc[i] = pick_d(); end
    dm[0] = 1; dc[0] = 3;
    run_seq(9);
    for (int i = 0; i < 4; i++) begin dm[i] = 1; dc[i] = 3; end
    run_seq(0);

    // Randomised delays, occasional timeouts and mid-sequence resets.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) begin dm[i] = pick_d(); dc[i] = pick_d(); end
      if ($urandom_range(0, 2) == 0) run_seq(int'($urandom_range(1, 20)));
      else run_seq(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adam_boot_seq.md
ADAM_BOOT_SEQ -- requirements
Module: adam_boot_seq

Interface
REQ-001 SHALL have parameter NO_CPUS, default 1: number of CPU reset/pause channels.
REQ-002 SHALL have parameter NO_MEMS, default 3: number of memory reset/pause channels.
REQ-003 SHALL have parameter RST_CYCLES, default 5: number of hold cycles after reset deassertion, range 1..255.
REQ-004 SHALL have parameter RST_BOOT_ADDR, default 32'h0100_0000: boot address presented to CPU0.
REQ-005 SHALL have parameter EN_BOOTSTRAP_CPU0, default 1: CPU0 is released by the sequencer.
REQ-006 SHALL have parameter EN_BOOTSTRAP_MEM0, default 1: MEM0 is released by the sequencer.
REQ-007 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles to wait for a pause ack, range 1..65535.
REQ-008 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-009 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-010 SHALL have port mem_rst, output, NO_MEMS: per-memory reset, active-high.
REQ-011 SHALL have port mem_pause_req, output, NO_MEMS: per-memory pause request.
REQ-012 SHALL have port mem_pause_ack, input, NO_MEMS: per-memory pause acknowledge.
REQ-013 SHALL have port cpu_rst, output, NO_CPUS: per-CPU reset, active-high.
REQ-014 SHALL have port cpu_pause_req, output, NO_CPUS: per-CPU pause request.
REQ-015 SHALL have port cpu_pause_ack, input, NO_CPUS: per-CPU pause acknowledge.
REQ-016 SHALL have port cpu0_boot_addr, output, 32: CPU0 boot address.
REQ-017 SHALL have port boot_done, output, 1: sequence complete.
REQ-018 SHALL have port boot_err, output, 1: sticky error; at least one ack timeout occurred.

Function
REQ-019 SHALL implement states HOLD, MEM_REL, MEM_WAIT, CPU_REL, CPU_WAIT, DONE.
REQ-020 HOLD: count cycles from 0; after exactly RST_CYCLES cycles in HOLD, go to MEM_REL if EN_BOOTSTRAP_MEM0, else CPU_REL if EN_BOOTSTRAP_CPU0, else DONE.
REQ-021 MEM_REL: one cycle; deassert mem_rst[0]; pause request stays high; go to MEM_WAIT.
REQ-022 MEM_WAIT: deassert mem_pause_req[0]; wait for mem_pause_ack[0]==0.
REQ-023 MEM_WAIT exit: on ack low, go to CPU_REL if EN_BOOTSTRAP_CPU0, else DONE.
REQ-024 CPU_REL, CPU_WAIT: identical to MEM_REL, MEM_WAIT, applied to cpu_rst[0], cpu_pause_req[0] and cpu_pause_ack[0]; exit to DONE.
REQ-025 In each WAIT state, a 16-bit counter SHALL start at 0 on entry and increment each cycle.
REQ-026 If the WAIT-state counter reaches ACK_TIMEOUT with ack still high, boot_err SHALL set and the FSM SHALL take its normal exit; the released channel is left running.
REQ-027 An ack already low on WAIT entry SHALL allow exit on the next clock edge (WAIT minimum 1 cycle).
REQ-028 Channels not bootstrapped (index>=1, or index 0 with the enable parameter 0) SHALL hold rst=1 and pause_req=1 permanently.
REQ-029 cpu0_boot_addr SHALL equal RST_BOOT_ADDR constantly, including during reset.
REQ-030 boot_done SHALL be 1 exactly while in DONE; DONE is terminal until reset.
REQ-031 Outputs SHALL be registered; no combinational path from any ack input to any output.
REQ-032 The MEM0 release SHALL precede the CPU0 release by at least 2 cycles.

Reset
REQ-033 While rst_n=0: state HOLD, counters 0, all mem_rst/cpu_rst bits =1, all pause_req bits =1, boot_done=0, boot_err=0.
REQ-034 Assertion of rst_n mid-sequence SHALL immediately restore the REQ-033 values asynchronously; after release the sequence SHALL restart from HOLD.
REQ-035 In HOLD, the RST_CYCLES count SHALL begin on the first rising clk edge after rst_n deasserts.

Verification
REQ-036 Defaults, acks drop 2 cycles after each pause_req falls -> mem_rst[0] falls after 5 cycles, then cpu_rst[0] falls, boot_done=1, boot_err=0, mem_rst[2:1]=2'b11.
REQ-037 mem_pause_ack[0] stuck high, ACK_TIMEOUT=4 -> boot_err=1 after 4 WAIT cycles; CPU0 still released; boot_done=1.
REQ-038 EN_BOOTSTRAP_MEM0=0 -> mem_rst[0] stays 1; CPU0 released after the RST_CYCLES hold.
REQ-039 Both enables 0 -> boot_done=1 after RST_CYCLES cycles; all rst and pause_req bits stay 1.
REQ-040 rst_n pulsed low during CPU_WAIT -> all outputs return to REQ-033 values in the same cycle; full sequence repeats after release.
REQ-041 Acks already low at release -> each WAIT lasts exactly 1 cycle; cpu0_boot_addr=32'h0100_0000 throughout.
